alu_op_sequencer: RTL and testbench

- Front-end controller for the lab ALU pipeline.
- Synchronizes and edge-detects the raw board buttons and captures operands on a valid press.
- Issues exactly one operation at a time to the pipeline-register/ALU path, waits a fixed pipeline latency, then captures the result and flags for the display stage.
- Also owns the display/operation mode counter driven by the change-mode button.

---
 rtl/alu_op_sequencer_if.sv | 34 +++
 rtl/alu_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Button/operand inputs, ALU return path and pipeline/display outputs of the ALU op sequencer.
// master is the sequencer side; slave is the board/pipeline side.
interface alu_op_sequencer_if #(
  parameter int N = 32
);
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic [3:0]   op_btn;
  logic         mode_btn;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic [3:0]   op_sel;
  logic [1:0]   change_mode;
  logic         issue_valid;
  logic         busy;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         result_valid;
  logic         err_multi;

  modport master (
    input  A_in, B_in, op_btn, mode_btn, alu_result, alu_flags,
    output A_num, B_num, op_sel, change_mode, issue_valid, busy,
           result, flags, result_valid, err_multi
  );

  modport slave (
    output A_in, B_in, op_btn, mode_btn, alu_result, alu_flags,
    input  A_num, B_num, op_sel, change_mode, issue_valid, busy,
           result, flags, result_valid, err_multi
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the lab ALU pipeline: button conditioning, single-op issue,
// fixed-latency result capture and the display mode counter.
module alu_op_sequencer #(
  parameter int N   = 32,
  parameter int LAT = 2
) (
  input logic                clk,
  input logic                reset,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  state_t       state_r;
  state_t       state_next_s;

  logic [3:0]   op_meta_r;
  logic [3:0]   op_sync_r;
  logic [3:0]   op_prev_r;
  logic         mode_meta_r;
  logic         mode_sync_r;
  logic         mode_prev_r;
  logic [3:0]   op_press_s;
  logic         mode_press_s;

  logic [N-1:0] a_num_r;
  logic [N-1:0] b_num_r;
  logic [3:0]   op_sel_r;
  logic [1:0]   mode_r;
  logic         issue_valid_r;
  logic         busy_r;
  logic [N-1:0] result_r;
  logic [3:0]   flags_r;
  logic         result_valid_r;
  logic         err_multi_r;
  logic [CW-1:0] cnt_r;

  logic [N-1:0] a_num_next_s;
  logic [N-1:0] b_num_next_s;
  logic [3:0]   op_sel_next_s;
  logic [1:0]   mode_next_s;
  logic         issue_next_s;
  logic         busy_next_s;
  logic [N-1:0] result_next_s;
  logic [3:0]   flags_next_s;
  logic         rv_next_s;
  logic         err_next_s;
  logic [CW-1:0] cnt_next_s;

  // Two-flop synchronizers plus a previous-value flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_meta_r   <= 4'b0000;
      op_sync_r   <= 4'b0000;
      op_prev_r   <= 4'b0000;
      mode_meta_r <= 1'b0;
      mode_sync_r <= 1'b0;
      mode_prev_r <= 1'b0;
    end else begin
      op_meta_r   <= bus.op_btn;
      op_sync_r   <= op_meta_r;
      op_prev_r   <= op_sync_r;
      mode_meta_r <= bus.mode_btn;
      mode_sync_r <= mode_meta_r;
      mode_prev_r <= mode_sync_r;
    end
  end

  assign op_press_s   = op_sync_r & ~op_prev_r;
  assign mode_press_s = mode_sync_r & ~mode_prev_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (is_one_hot(op_press_s)) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: state_next_s = WAIT;
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values for every registered output; strobes follow the state being entered.
  always_comb begin
    a_num_next_s  = a_num_r;
    b_num_next_s  = b_num_r;
    op_sel_next_s = op_sel_r;
    result_next_s = result_r;
    flags_next_s  = flags_r;
    cnt_next_s    = cnt_r;
    err_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_one_hot(op_press_s)) begin
          a_num_next_s  = bus.A_in;
          b_num_next_s  = bus.B_in;
          op_sel_next_s = op_press_s;
        end else if (op_press_s != 4'b0000) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = 1'b0;
        end
      end
      ISSUE: cnt_next_s = CNT_LOAD;
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          result_next_s = bus.alu_result;
          flags_next_s  = bus.alu_flags;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      DONE:    cnt_next_s = CNT_ZERO;
      default: cnt_next_s = CNT_ZERO;
    endcase
    if (mode_press_s) begin
      mode_next_s = mode_r + 2'd1;
    end else begin
      mode_next_s = mode_r;
    end
    issue_next_s = (state_next_s == ISSUE);
    busy_next_s  = (state_next_s == ISSUE) || (state_next_s == WAIT);
    rv_next_s    = (state_next_s == DONE);
  end

  // Output and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_num_r        <= {N{1'b0}};
      b_num_r        <= {N{1'b0}};
      op_sel_r       <= 4'b0000;
      mode_r         <= 2'b00;
      issue_valid_r  <= 1'b0;
      busy_r         <= 1'b0;
      result_r       <= {N{1'b0}};
      flags_r        <= 4'b0000;
      result_valid_r <= 1'b0;
      err_multi_r    <= 1'b0;
      cnt_r          <= CNT_ZERO;
    end else begin
      a_num_r        <= a_num_next_s;
      b_num_r        <= b_num_next_s;
      op_sel_r       <= op_sel_next_s;
      mode_r         <= mode_next_s;
      issue_valid_r  <= issue_next_s;
      busy_r         <= busy_next_s;
      result_r       <= result_next_s;
      flags_r        <= flags_next_s;
      result_valid_r <= rv_next_s;
      err_multi_r    <= err_next_s;
      cnt_r          <= cnt_next_s;
    end
  end

  assign bus.A_num        = a_num_r;
  assign bus.B_num        = b_num_r;
  assign bus.op_sel       = op_sel_r;
  assign bus.change_mode  = mode_r;
  assign bus.issue_valid  = issue_valid_r;
  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.flags        = flags_r;
  assign bus.result_valid = result_valid_r;
  assign bus.err_multi    = err_multi_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU pipe returns results LAT cycles
// after issue; expected issues/results are queued when ops are pressed.
module tb_alu_op_sequencer;
  localparam int N   = 32;
  localparam int LAT = 2;
  localparam logic [N+3:0] POISON = {4'b1010, {N{1'b1}}};

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic [N-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.N(N)) bus ();
  alu_op_sequencer #(.N(N), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int n_issue = 0;
  int n_result = 0;
  int err_seen = 0;
  logic inflight = 1'b0;
  logic [1:0] exp_mode = 2'b00;

  function automatic logic [N+3:0] alu_f(input logic [3:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0001: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[N-1:0];
        c = wide[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'b0010: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[N-1:0];
        c = wide[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'b0100: r = a & b;
      4'b1000: r = a ^ b;
      default: r = {N{1'b0}};
    endcase
    return {r[N-1], (r == {N{1'b0}}), c, v, r};
  endfunction

  // Behavioural ALU pipeline: result emerges LAT cycles after the issue cycle.
  logic [N+3:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.issue_valid ? alu_f(bus.op_sel, bus.A_num, bus.B_num) : POISON;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alu_result = pipe[LAT-1][N-1:0];
  assign bus.alu_flags  = pipe[LAT-1][N+3:N];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  // One clock; observe DUT strobes against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.err_multi === 1'b1) err_seen++;
    if (bus.issue_valid === 1'b1) begin
      n_issue++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: issue_valid=1 at cycle %0d, required no issue", cyc);
      end else if ({bus.A_num, bus.B_num, bus.op_sel} !== {exp_q[0].a, exp_q[0].b, exp_q[0].op}) begin
        errors++;
        $display("FAIL issue_operands: A=%0h B=%0h op=%b, required A=%0h B=%0h op=%b",
                 bus.A_num, bus.B_num, bus.op_sel, exp_q[0].a, exp_q[0].b, exp_q[0].op);
      end
      issue_cyc = cyc;
      inflight = 1'b1;
    end
    if (bus.result_valid === 1'b1) begin
      n_result++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: result_valid=1 at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({bus.result, bus.flags} !== {e.res, e.flg}) begin
          errors++;
          $display("FAIL result_value: result=%0h flags=%b, required result=%0h flags=%b",
                   bus.result, bus.flags, e.res, e.flg);
        end
        checks++;
        if (cyc - issue_cyc != LAT + 1) begin
          errors++;
          $display("FAIL result_latency: %0d cycles after issue, required %0d", cyc - issue_cyc, LAT + 1);
        end
      end
      inflight = 1'b0;
    end
    checks++;
    if (bus.busy !== inflight) begin
      errors++;
      $display("FAIL busy: busy=%b at cycle %0d, required %b", bus.busy, cyc, inflight);
    end
  endtask

  task automatic press_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+3:0] t;
    exp_t e;
    bus.A_in = a;
    bus.B_in = b;
    bus.op_btn = op;
    if ($countones(op) == 1) begin
      t = alu_f(op, a, b);
      e.a = a; e.b = b; e.op = op; e.res = t[N-1:0]; e.flg = t[N+3:N];
      exp_q.push_back(e);
    end
    tick();
    bus.op_btn = 4'b0000;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy === 1'b1) && k < 60) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL wait_done_timeout: pending=%0d busy=%b after %0d cycles, required 0/0",
               exp_q.size(), bus.busy, k);
    end
    tick();
  endtask

  task automatic wait_issue(input int base);
    int k = 0;
    while (n_issue == base && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (n_issue == base) begin
      errors++;
      $display("FAIL wait_issue_timeout: issues=%0d, required %0d", n_issue, base + 1);
    end
  endtask

  task automatic test_reset();
    logic [3*N+13:0] ov;
    reset = 1'b1;
    bus.A_in = {N{1'b0}};
    bus.B_in = {N{1'b0}};
    bus.op_btn = 4'b0000;
    bus.mode_btn = 1'b0;
    exp_q.delete();
    inflight = 1'b0;
    exp_mode = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ov = {bus.A_num, bus.B_num, bus.op_sel, bus.change_mode, bus.issue_valid, bus.busy,
            bus.result, bus.flags, bus.result_valid, bus.err_multi};
      checks++;
      if (ov !== '0) begin
        errors++;
        $display("FAIL reset_idle: outputs=%0h at idle cycle %0d, required 0", ov, i);
      end
    end
  endtask

  task automatic test_mode();
    for (int i = 0; i < 5; i++) begin
      bus.mode_btn = 1'b1;
      tick();
      bus.mode_btn = 1'b0;
      tick(); tick(); tick();
      exp_mode = exp_mode + 2'd1;
      checks++;
      if (bus.change_mode !== exp_mode) begin
        errors++;
        $display("FAIL mode_step: change_mode=%0d after press %0d, required %0d",
                 bus.change_mode, i + 1, exp_mode);
      end
    end
  endtask

  task automatic test_single_op();
    int bi = n_issue;
    int br = n_result;
    press_op(4'b0001, 32'd5, 32'd3);
    wait_done();
    checks++;
    if (n_issue - bi != 1 || n_result - br != 1) begin
      errors++;
      $display("FAIL single_counts: issues=%0d results=%0d, required 1 1", n_issue - bi, n_result - br);
    end
    checks++;
    if ({bus.result, bus.flags} !== {32'd8, 4'b0000}) begin
      errors++;
      $display("FAIL single_hold: result=%0d flags=%b, required 8 0000", bus.result, bus.flags);
    end
  endtask

  task automatic test_hold();
    int bi = n_issue;
    logic [N+3:0] t;
    exp_t e;
    bus.A_in = 32'hF0F0_1234;
    bus.B_in = 32'h0FF0_FF00;
    bus.op_btn = 4'b0100;
    t = alu_f(4'b0100, bus.A_in, bus.B_in);
    e.a = bus.A_in; e.b = bus.B_in; e.op = 4'b0100; e.res = t[N-1:0]; e.flg = t[N+3:N];
    exp_q.push_back(e);
    for (int i = 0; i < 40; i++) tick();
    bus.op_btn = 4'b0000;
    wait_done();
    checks++;
    if (n_issue - bi != 1 || bus.op_sel !== 4'b0100) begin
      errors++;
      $display("FAIL hold_single_issue: issues=%0d op_sel=%b, required 1 0100", n_issue - bi, bus.op_sel);
    end
  endtask

  task automatic test_multi();
    int bi = n_issue;
    int be = err_seen;
    press_op(4'b0011, 32'd1, 32'd2);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (err_seen - be != 1) begin
      errors++;
      $display("FAIL multi_err_pulse: err_multi high %0d cycles, required 1", err_seen - be);
    end
    checks++;
    if (n_issue != bi) begin
      errors++;
      $display("FAIL multi_no_issue: issues=%0d, required 0", n_issue - bi);
    end
  endtask

  task automatic test_drop_during_wait();
    int bi = n_issue;
    int br = n_result;
    int be = err_seen;
    press_op(4'b0001, 32'd100, 32'd23);
    wait_issue(bi);
    bus.op_btn = 4'b0010;
    tick();
    bus.op_btn = 4'b0000;
    wait_done();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (n_issue - bi != 1 || n_result - br != 1 || err_seen != be) begin
      errors++;
      $display("FAIL drop_in_wait: issues=%0d results=%0d errs=%0d, required 1 1 0",
               n_issue - bi, n_result - br, err_seen - be);
    end
    checks++;
    if (bus.op_sel !== 4'b0001) begin
      errors++;
      $display("FAIL drop_op_sel: op_sel=%b, required 0001", bus.op_sel);
    end
  endtask

  task automatic test_mode_and_op();
    int bi = n_issue;
    exp_mode = exp_mode + 2'd1;
    bus.mode_btn = 1'b1;
    press_op(4'b1000, 32'hAAAA_5555, 32'h0F0F_0F0F);
    bus.mode_btn = 1'b0;
    wait_done();
    checks++;
    if (bus.change_mode !== exp_mode || n_issue - bi != 1) begin
      errors++;
      $display("FAIL mode_with_op: change_mode=%0d issues=%0d, required %0d 1",
               bus.change_mode, n_issue - bi, exp_mode);
    end
  endtask

  task automatic test_reset_mid_op();
    int bi = n_issue;
    int br;
    logic [3*N+13:0] ov;
    press_op(4'b0010, 32'd50, 32'd8);
    wait_issue(bi);
    tick();
    reset = 1'b1;
    #1;
    ov = {bus.A_num, bus.B_num, bus.op_sel, bus.change_mode, bus.issue_valid, bus.busy,
          bus.result, bus.flags, bus.result_valid, bus.err_multi};
    checks++;
    if (ov !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: outputs=%0h, required 0", ov);
    end
    exp_q.delete();
    inflight = 1'b0;
    exp_mode = 2'b00;
    br = n_result;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (n_result != br) begin
      errors++;
      $display("FAIL reset_no_result: results=%0d after abort, required 0", n_result - br);
    end
    press_op(4'b0001, 32'd7, 32'd9);
    wait_done();
    checks++;
    if (n_result - br != 1 || bus.result !== 32'd16) begin
      errors++;
      $display("FAIL reset_fresh_op: results=%0d result=%0d, required 1 16", n_result - br, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4];
    int br = n_result;
    ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b0100; ops[3] = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      press_op(ops[$urandom_range(0, 3)], $urandom, $urandom);
      wait_done();
    end
    press_op(4'b0010, 32'd3, 32'd5);
    wait_done();
    checks++;
    if (n_result - br != 9 || bus.flags !== 4'b1010) begin
      errors++;
      $display("FAIL back_to_back: results=%0d flags=%b, required 9 1010", n_result - br, bus.flags);
    end
  endtask

  initial begin
    bus.A_in = {N{1'b0}};
    bus.B_in = {N{1'b0}};
    bus.op_btn = 4'b0000;
    bus.mode_btn = 1'b0;
    test_reset();
    test_mode();
    test_single_op();
    test_hold();
    test_multi();
    test_drop_during_wait();
    test_mode_and_op();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
